// File: rtl/alu_iter_exec_pkg.sv
// Shared constants for the iterative execute unit: ALUop classes, funct fields,
// 4-bit ALU control codes and FSM state encodings.
package alu_iter_exec_pkg;

    // ALUop classes from the main decoder
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    // funct3 / funct7 field values recognised for R-type ops
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MDU     = 7'b0000001;

    // ALU control codes
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_DIV = 4'b0100;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_MUL = 4'b0111;

    // FSM states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/alu_iter_exec_if.sv
// Request/result bundle between decode, the execute unit and writeback.
interface alu_iter_exec_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    // Producer of requests / consumer of results
    modport master (
        output in_valid, alu_op, funct7, funct3, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal, busy
    );

    // Execute unit side
    modport slave (
        input  in_valid, alu_op, funct7, funct3, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, zero, illegal, busy
    );
endinterface

// File: rtl/alu_iter_exec_op_decode.sv
// Combinational ALUop/funct3/funct7 -> {ctrl, illegal} decoder.
// Kept standalone so the hazard unit can reuse it.
module alu_op_decode
    import alu_iter_exec_pkg::*;
#(
    parameter bit HAS_MDU = 1'b1
) (
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [3:0] o_ctrl,
    output logic       o_illegal
);

    // Decode; unknown encodings flag illegal and fall back to ADD control
    always_comb begin
        o_ctrl    = CTRL_ADD;
        o_illegal = 1'b0;
        case (i_alu_op)
            ALUOP_MEM: o_ctrl = CTRL_ADD;
            ALUOP_BR:  o_ctrl = CTRL_SUB;
            ALUOP_R: begin
                case ({i_funct7, i_funct3})
                    {F7_BASE, F3_ADD_SUB}: o_ctrl = CTRL_ADD;
                    {F7_ALT,  F3_ADD_SUB}: o_ctrl = CTRL_SUB;
                    {F7_BASE, F3_AND}:     o_ctrl = CTRL_AND;
                    {F7_BASE, F3_OR}:      o_ctrl = CTRL_OR;
                    {F7_MDU,  F3_ADD_SUB}: begin
                        if (HAS_MDU) o_ctrl = CTRL_MUL;
                        else         o_illegal = 1'b1;
                    end
                    {F7_MDU,  F3_DIV}: begin
                        if (HAS_MDU) o_ctrl = CTRL_DIV;
                        else         o_illegal = 1'b1;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_iter_exec.sv
// Execute unit: single-cycle ADD/SUB/AND/OR, iterative shift-add MUL and
// restoring signed DIV, with valid/ready on both sides.
// The first MUL/DIV iteration is folded into the accept cycle, so the
// remaining XLEN-1 iterations plus DONE (and FIX for DIV) give XLEN+1 / XLEN+2.
module alu_iter_exec
    import alu_iter_exec_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          HAS_MDU = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    alu_iter_exec_if.slave bus
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      r_state, w_state_nxt;
    logic [XLEN-1:0] r_acc, w_acc_nxt;
    logic [XLEN-1:0] r_opa, w_opa_nxt;
    logic [XLEN-1:0] r_opb, w_opb_nxt;
    logic [XLEN-1:0] r_rem, w_rem_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic            r_neg, w_neg_nxt;

    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_illegal;

    logic [3:0]      w_ctrl;
    logic            w_dec_illegal;
    logic            w_idle, w_in_ready, w_accept, w_fast, w_load, w_load_ill;
    logic [XLEN-1:0] w_a, w_b, w_abs_a, w_abs_b, w_fast_res, w_load_res;
    logic            w_a_neg, w_b_neg, w_div_ovf, w_is_mul;
    logic [XLEN-1:0] w_src_acc, w_src_opa, w_src_opb, w_src_rem;
    logic [XLEN-1:0] w_mul_acc, w_mul_opa, w_mul_opb;
    logic [XLEN:0]   w_rem_sh, w_rem_diff;
    logic            w_div_ge;
    logic [XLEN-1:0] w_div_rem, w_div_quo;
    logic            w_last;

    alu_op_decode #(
        .HAS_MDU (HAS_MDU)
    ) u_decode (
        .i_alu_op  (bus.alu_op),
        .i_funct3  (bus.funct3),
        .i_funct7  (bus.funct7),
        .o_ctrl    (w_ctrl),
        .o_illegal (w_dec_illegal)
    );

    assign w_a        = bus.operand_a;
    assign w_b        = bus.operand_b;
    assign w_a_neg    = w_a[XLEN-1];
    assign w_b_neg    = w_b[XLEN-1];
    assign w_abs_a    = w_a_neg ? (~w_a + 1'b1) : w_a;
    assign w_abs_b    = w_b_neg ? (~w_b + 1'b1) : w_b;
    assign w_div_ovf  = (w_a == MinNeg) && (w_b == {XLEN{1'b1}});
    assign w_is_mul   = (w_ctrl == CTRL_MUL);

    assign w_idle     = (r_state == ST_IDLE);
    assign w_in_ready = w_idle && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = (r_cnt == CntW'(XLEN - 1));

    // Single-cycle result; clears w_fast for ops that need iteration
    always_comb begin
        w_fast     = 1'b1;
        w_fast_res = '0;
        if (!w_dec_illegal) begin
            case (w_ctrl)
                CTRL_ADD: w_fast_res = w_a + w_b;
                CTRL_SUB: w_fast_res = w_a - w_b;
                CTRL_AND: w_fast_res = w_a & w_b;
                CTRL_OR:  w_fast_res = w_a | w_b;
                CTRL_MUL: w_fast = 1'b0;
                CTRL_DIV: begin
                    if (w_b == '0)     w_fast_res = {XLEN{1'b1}};
                    else if (w_div_ovf) w_fast_res = MinNeg;
                    else                w_fast = 1'b0;
                end
                default: w_fast_res = '0;
            endcase
        end
    end

    // Step operands: fresh operands in IDLE (first folded step), else the iteration regs
    always_comb begin
        w_src_acc = w_idle ? '0 : r_acc;
        w_src_opa = w_idle ? (w_is_mul ? w_a : w_abs_a) : r_opa;
        w_src_opb = w_idle ? (w_is_mul ? w_b : w_abs_b) : r_opb;
        w_src_rem = w_idle ? '0 : r_rem;
    end

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        w_mul_acc  = w_src_opb[0] ? (w_src_acc + w_src_opa) : w_src_acc;
        w_mul_opa  = w_src_opa << 1;
        w_mul_opb  = w_src_opb >> 1;
        // Remainder stays below the divisor (<= 2^(XLEN-1)), so bit XLEN is a clean borrow
        w_rem_sh   = {w_src_rem, w_src_opa[XLEN-1]};
        w_rem_diff = w_rem_sh - {1'b0, w_src_opb};
        w_div_ge   = !w_rem_diff[XLEN];
        w_div_rem  = w_div_ge ? w_rem_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        w_div_quo  = {w_src_opa[XLEN-2:0], w_div_ge};
    end

    // FSM and iteration next-state
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_opa_nxt   = r_opa;
        w_opb_nxt   = r_opb;
        w_rem_nxt   = r_rem;
        w_cnt_nxt   = r_cnt;
        w_neg_nxt   = r_neg;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_fast) begin
                    w_cnt_nxt = CntW'(1);
                    if (w_is_mul) begin
                        w_state_nxt = ST_MUL;
                        w_acc_nxt   = w_mul_acc;
                        w_opa_nxt   = w_mul_opa;
                        w_opb_nxt   = w_mul_opb;
                    end else begin
                        w_state_nxt = ST_DIV;
                        w_rem_nxt   = w_div_rem;
                        w_opa_nxt   = w_div_quo;
                        w_opb_nxt   = w_src_opb;
                        w_neg_nxt   = w_a_neg ^ w_b_neg;
                    end
                end
            end
            ST_MUL: begin
                w_acc_nxt = w_mul_acc;
                w_opa_nxt = w_mul_opa;
                w_opb_nxt = w_mul_opb;
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DIV: begin
                w_rem_nxt = w_div_rem;
                w_opa_nxt = w_div_quo;
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_last) w_state_nxt = ST_FIX;
            end
            ST_FIX: begin
                w_acc_nxt   = r_neg ? (~r_opa + 1'b1) : r_opa;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM and iteration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_opa   <= w_opa_nxt;
            r_opb   <= w_opb_nxt;
            r_rem   <= w_rem_nxt;
            r_cnt   <= w_cnt_nxt;
            r_neg   <= w_neg_nxt;
        end
    end

    assign w_load     = (w_accept && w_fast) || (r_state == ST_DONE);
    assign w_load_res = (r_state == ST_DONE) ? r_acc : w_fast_res;
    assign w_load_ill = (r_state == ST_DONE) ? 1'b0 : w_dec_illegal;

    // Output register: load wins over consume, otherwise hold under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_load_res;
            r_zero      <= (w_load_res == '0);
            r_illegal   <= w_load_ill;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.illegal   = r_illegal;
    assign bus.busy      = !w_idle;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec (XLEN=32, HAS_MDU=1).
module tb_alu_iter_exec;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_iter_exec_if #(.XLEN(XLEN)) bus ();

    alu_iter_exec #(
        .XLEN    (XLEN),
        .HAS_MDU (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result, illegal flag and accept-to-valid latency from the op rules
    function automatic void model(input logic [1:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] res,
                                  output logic ill, output int lat);
        res = 32'h0;
        ill = 1'b0;
        lat = 1;
        if (op == 2'b00)                              res = a + b;
        else if (op == 2'b01)                         res = a - b;
        else if (op == 2'b10 && f7 == 7'h00 && f3 == 3'd0) res = a + b;
        else if (op == 2'b10 && f7 == 7'h20 && f3 == 3'd0) res = a - b;
        else if (op == 2'b10 && f7 == 7'h00 && f3 == 3'd7) res = a & b;
        else if (op == 2'b10 && f7 == 7'h00 && f3 == 3'd6) res = a | b;
        else if (op == 2'b10 && f7 == 7'h01 && f3 == 3'd0) begin
            res = a * b;
            lat = 33;
        end else if (op == 2'b10 && f7 == 7'h01 && f3 == 3'd4) begin
            if (b == 32'h0)                                 res = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
            else begin
                res = 32'(int'(a) / int'(b));
                lat = 34;
            end
        end else begin
            ill = 1'b1;
        end
    endfunction

    // Issue one op (out_ready=1), measure latency, check the result against the model
    task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e_res;
        logic        e_ill;
        int          e_lat;
        int          lat;
        int          guard;
        logic        rdy_leak;
        model(op, f3, f7, a, b, e_res, e_ill, e_lat);
        bus.alu_op    = op;
        bus.funct3    = f3;
        bus.funct7    = f7;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.in_valid  = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ".accept"}, 32'(guard < 100), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat      = 1;
        rdy_leak = 1'b0;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_leak = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(e_lat));
        check({tag, ".res"}, bus.result, e_res);
        check({tag, ".zero"}, 32'(bus.zero), 32'(e_res == 32'h0));
        check({tag, ".ill"}, 32'(bus.illegal), 32'(e_ill));
        if (e_lat > 1) check({tag, ".rdy_low"}, 32'(rdy_leak), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3_tab [5];
        logic [6:0]  f7_tab [4];

        f3_tab = '{3'd0, 3'd4, 3'd6, 3'd7, 3'd0};
        f7_tab = '{7'h00, 7'h20, 7'h01, 7'h01};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.alu_op    = 2'b00;
        bus.funct3    = 3'd0;
        bus.funct7    = 7'd0;
        bus.operand_a = 32'h0;
        bus.operand_b = 32'h0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.result", bus.result, 32'h0);
        check("rst.zero", 32'(bus.zero), 32'd0);
        check("rst.illegal", 32'(bus.illegal), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back ADD 5+7 then SUB 7-7
        bus.alu_op = 2'b10; bus.funct3 = 3'd0; bus.funct7 = 7'h00;
        bus.operand_a = 32'd5; bus.operand_b = 32'd7; bus.in_valid = 1'b1;
        @(negedge clk);
        check("b2b.rdy0", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.funct7 = 7'h20; bus.operand_a = 32'd7; bus.operand_b = 32'd7;
        @(negedge clk);
        check("b2b.add.valid", 32'(bus.out_valid), 32'd1);
        check("b2b.add.res", bus.result, 32'd12);
        check("b2b.add.zero", 32'(bus.zero), 32'd0);
        check("b2b.rdy1", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b.sub.valid", 32'(bus.out_valid), 32'd1);
        check("b2b.sub.res", bus.result, 32'd0);
        check("b2b.sub.zero", 32'(bus.zero), 32'd1);
        @(posedge clk);
        #1;

        // Directed cases
        run_op("mem", 2'b00, 3'b010, 7'h00, 32'h1000, 32'h24);
        run_op("br", 2'b01, 3'b000, 7'h00, 32'd9, 32'd9);
        run_op("rsvd", 2'b11, 3'b000, 7'h00, 32'd3, 32'd4);
        run_op("and", 2'b10, 3'd7, 7'h00, 32'hF0F0_1234, 32'h0FF0_FF00);
        run_op("or", 2'b10, 3'd6, 7'h00, 32'hF000_0001, 32'h0000_F002);
        run_op("mul", 2'b10, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'd3);
        run_op("div", 2'b10, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2);
        run_op("div0", 2'b10, 3'd4, 7'h01, 32'd5, 32'd0);
        run_op("divovf", 2'b10, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);

        // Backpressure: ADD 1+1 held for 5 cycles while the next op waits
        bus.out_ready = 1'b0;
        bus.alu_op = 2'b10; bus.funct3 = 3'd0; bus.funct7 = 7'h00;
        bus.operand_a = 32'd1; bus.operand_b = 32'd1; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.operand_a = 32'd3; bus.operand_b = 32'd4;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp.valid", 32'(bus.out_valid), 32'd1);
            check("bp.res", bus.result, 32'd2);
            check("bp.rdy", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp.release.rdy", 32'(bus.in_ready), 32'd1);
        check("bp.release.res", bus.result, 32'd2);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp.next.valid", 32'(bus.out_valid), 32'd1);
        check("bp.next.res", bus.result, 32'd7);
        @(posedge clk);
        #1;

        // Reset in the middle of a DIV
        bus.funct3 = 3'd4; bus.funct7 = 7'h01;
        bus.operand_a = 32'd100; bus.operand_b = 32'd3; bus.in_valid = 1'b1;
        @(negedge clk);
        check("rstdiv.rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 check("rstdiv.busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rstdiv.valid", 32'(bus.out_valid), 32'd0);
        check("rstdiv.busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_op("postrst", 2'b10, 3'd0, 7'h00, 32'd20, 32'd22);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : f3_tab[$urandom_range(0, 4)];
            f7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : f7_tab[$urandom_range(0, 3)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(1, 9)); end
                3: b = 32'h0 - 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), op, f3, f7, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
